pucch_alpha_seq_gen: RTL and testbench
======================================

Name: pucch_alpha_seq_gen

Overview:
- Parametrised successor of the single-alpha cyclic-shift generator for PUCCH formats 0/1/3/4 DMRS.
- Per request, it computes the base-sequence group u and streams cyclic-shift indices alpha(l) = (m0 + mcs + mint + ncs(nslot, l)) mod N_SC for a contiguous run of symbols.
- Supports normal and extended CP, interlaced mapping (mint = 5*nIRB), configurable Gold-sequence advance rate, and valid/ready back-pressure.
- Contains its own length-31 Gold sequence generator. Sits between the PUCCH control FSM and the low-PAPR sequence ROM/rotator.

Parameters:
PAR_BITS, 8, Gold-sequence bits produced per clock; legal values 1, 2, 4, 8.
NC, 1600, Gold-sequence fast-forward offset Nc.
N_SC, 12, subcarriers per RB (modulus of alpha); fixed at 12, kept for documentation.
NIRB_W, 4, width of interlace RB index.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_start  in  1  one-cycle request; captures all i_* config inputs
i_ext_cp  in  1  1 = extended CP (12 symb/slot), 0 = normal (14)
i_m0  in  4  initial cyclic shift, 0..11
i_mcs  in  4  sequence cyclic shift, 0..11
i_interlace  in  1  1 = mint = 5*i_nirb, 0 = mint = 0
i_nirb  in  NIRB_W  RB index within interlace
i_nslot  in  8  slot number, 0..159 (0..39 when ext CP)
i_nid  in  10  hopping/cell ID, 0..1023
i_sym_start  in  4  first symbol l' within slot
i_nsym  in  4  number of symbols to stream, 1..14
i_ready  in  1  downstream ready
o_busy  out  1  high from accepted start until last beat accepted
o_err  out  1  one-cycle pulse, start rejected
o_u  out  5  nid mod 30, valid while o_busy
o_valid  out  1  output beat valid
o_alpha  out  4  cyclic-shift index 0..11
o_ncs  out  8  ncs for this symbol
o_sym_idx  out  4  absolute symbol index l'+l
o_last  out  1  final beat of request

Behaviour:
- Reset: all outputs 0; FSM to IDLE; LFSRs cleared. Reset mid-operation aborts; no partial beats after release.
- Nsymb = 12 if ext CP, else 14.
- Gold sequence:
  - x1 initialised to 1 (bit0 = 1, others 0); x2 initialised to c_init = i_nid.
  - c(n) = x1(n+NC) XOR x2(n+NC). Both LFSRs advance PAR_BITS steps per clock.
- FSM IDLE: on i_start, validate the request. Reject with o_err for one cycle and stay IDLE if any of:
  - m0 > 11 or mcs > 11;
  - nsym == 0;
  - sym_start + nsym > Nsymb;
  - nslot > 159 (normal CP) or nslot > 39 (ext CP).
  Otherwise register the config, set o_busy, go to LOAD.
- LOAD (1 cycle):
  - Initialise LFSRs.
  - skip = NC + 8*(Nsymb*nslot + sym_start), held in 17-bit counter.
  - Register u = nid mod 30.
  - Register k = (m0 + mcs + (interlace ? (5*nirb) mod 12 : 0)) mod 12.
- ADVANCE: step LFSRs, decrement skip by PAR_BITS per clock, for skip/PAR_BITS clocks (skip is always a multiple of 8). Then go to COLLECT.
- COLLECT: gather 8 bits LSB-first, ncs = sum c(n+m)*2^m over m = 0..7; takes 8/PAR_BITS clocks. Then go to STREAM.
- STREAM:
  - Present o_valid = 1, o_ncs, o_alpha = (k + ncs) mod 12, o_sym_idx, o_last = (beat == nsym-1).
  - Outputs are held stable while o_valid && !i_ready.
  - On handshake: if last, return to IDLE and clear o_busy the next cycle; else go to COLLECT for the next symbol.
  - For PAR_BITS=8, COLLECT of symbol n+1 overlaps STREAM of symbol n via a one-entry skid register, so sustained throughput is 1 beat/clock with i_ready high.
- Timing:
  - Latency from i_start to first o_valid = 2 + skip/PAR_BITS + 8/PAR_BITS clocks (PAR_BITS=8, nslot=0, l'=0: 2 + 200 + 1 = 203).
  - i_start while o_busy is ignored (no o_err).
  - Config inputs are sampled only at accepted start.
- Arithmetic: mod 30 and mod 12 by multiply-reciprocal or small subtract chain; results exact for all legal inputs.

Test Plan:
- nid=0, nslot=0, l'=0, nsym=14, m0=mcs=0, PAR_BITS=8, i_ready=1 -> first o_valid at cycle 203 after start; 14 consecutive beats, o_sym_idx 0..13, o_ncs matching the TS 38.211 5.2.1 golden model, o_last on beat 14, o_u=0.
- nid=1023, nslot=159, ext CP=0, l'=10, nsym=4, m0=11, mcs=11 -> o_u=3; o_alpha = (10 + ncs) mod 12 per model; o_sym_idx 10..13.
- interlace=1, nirb=7 (mint=35, mod 12 = 11), m0=3, mcs=0 -> o_alpha = (2 + ncs) mod 12 for every beat.
- i_ready toggled randomly, PAR_BITS=1 and 8 -> outputs stable during stall, no beats lost or duplicated; PAR_BITS=1 latency = 2 + skip + 8.
- Error cases: nsym=0; ext CP with l'=10, nsym=3; nslot=40 with ext CP; m0=12 -> each gives o_err pulse, o_busy stays 0. i_start during busy -> ignored.
- Assert rst mid-ADVANCE and mid-STREAM -> all outputs 0 immediately; a new request after release produces correct full sequence.

Source files
------------

// File: rtl/pucch_alpha_seq_gen.sv
// PUCCH DMRS cyclic-shift generator: computes group u and streams alpha(l) per symbol,
// driven by an internal length-31 Gold sequence advancing PAR_BITS steps per clock.
module pucch_alpha_seq_gen #(
  parameter int unsigned PAR_BITS = 8,
  parameter int unsigned NC       = 1600,
  parameter int unsigned N_SC     = 12,
  parameter int unsigned NIRB_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ext_cp,
  input  logic [3:0]        i_m0,
  input  logic [3:0]        i_mcs,
  input  logic              i_interlace,
  input  logic [NIRB_W-1:0] i_nirb,
  input  logic [7:0]        i_nslot,
  input  logic [9:0]        i_nid,
  input  logic [3:0]        i_sym_start,
  input  logic [3:0]        i_nsym,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_err,
  output logic [4:0]        o_u,
  output logic              o_valid,
  output logic [3:0]        o_alpha,
  output logic [7:0]        o_ncs,
  output logic [3:0]        o_sym_idx,
  output logic              o_last
);

  typedef enum logic [2:0] {StIdle, StLoad, StAdvance, StCollect, StStream} state_e;

  // With a full byte per clock the next symbol is gathered while the current one is presented.
  localparam bit          Overlap = (PAR_BITS == 8);
  localparam logic [7:0]  BitMask = 8'((1 << PAR_BITS) - 1);
  localparam logic [16:0] ParStep = 17'(PAR_BITS);
  localparam logic [3:0]  ParPos  = 4'(PAR_BITS);

  function automatic logic [30:0] step_x1(input logic [30:0] s);
    logic [30:0] r;
    r = s;
    for (int i = 0; i < int'(PAR_BITS); i++) r = {r[3] ^ r[0], r[30:1]};
    return r;
  endfunction

  function automatic logic [30:0] step_x2(input logic [30:0] s);
    logic [30:0] r;
    r = s;
    for (int i = 0; i < int'(PAR_BITS); i++) r = {r[3] ^ r[2] ^ r[1] ^ r[0], r[30:1]};
    return r;
  endfunction

  // Reciprocal 5462/2^16 gives an exact quotient by 12 for x < 8160.
  function automatic logic [3:0] mod12(input logic [15:0] x);
    logic [15:0] q;
    q = 16'(({16'd0, x} * 32'd5462) >> 16);
    return 4'(x - 16'(q * 16'(N_SC)));
  endfunction

  // Reciprocal 2185/2^16 gives an exact quotient by 30 for x < 1024.
  function automatic logic [4:0] mod30(input logic [9:0] x);
    logic [5:0] q;
    q = 6'(({12'd0, x} * 22'd2185) >> 16);
    return 5'(x - 10'(q * 10'd30));
  endfunction

  state_e            state_q, state_d;
  logic              ext_cp_q, interlace_q;
  logic [3:0]        m0_q, mcs_q, sym_start_q, nsym_q;
  logic [NIRB_W-1:0] nirb_q;
  logic [7:0]        nslot_q;
  logic [9:0]        nid_q;
  logic [30:0]       x1_q, x1_d, x2_q, x2_d;
  logic [16:0]       skip_q, skip_d;
  logic [2:0]        pos_q, pos_d;
  logic [7:0]        coll_q, coll_d, ncs_q, ncs_d, skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic [3:0]        beat_q, beat_d, sym_q, sym_d, k_q, k_d;
  logic [4:0]        u_q, u_d;
  logic              err_q, err_d, capture;

  logic [30:0] x1_nxt, x2_nxt;
  logic [7:0]  c_bits, coll_merged;
  logic [3:0]  nsymb_in, nsymb_cfg, mint12;
  logic [11:0] sym_base;
  logic [16:0] load_skip;
  logic        req_bad, coll_done, beat_last, fill;

  assign x1_nxt      = step_x1(x1_q);
  assign x2_nxt      = step_x2(x2_q);
  assign c_bits      = (x1_q[7:0] ^ x2_q[7:0]) & BitMask;
  assign coll_merged = coll_q | (c_bits << pos_q);
  assign coll_done   = (4'(pos_q) + ParPos) == 4'd8;

  assign nsymb_in = i_ext_cp ? 4'd12 : 4'd14;
  assign req_bad  = (i_m0 > 4'd11) || (i_mcs > 4'd11) || (i_nsym == 4'd0) ||
                    (({1'b0, i_sym_start} + {1'b0, i_nsym}) > {1'b0, nsymb_in}) ||
                    (i_nslot > (i_ext_cp ? 8'd39 : 8'd159));

  assign nsymb_cfg = ext_cp_q ? 4'd12 : 4'd14;
  assign sym_base  = 12'(12'(nsymb_cfg) * 12'(nslot_q)) + 12'(sym_start_q);
  assign load_skip = 17'(NC) + {2'b00, sym_base, 3'b000};
  assign mint12    = interlace_q ? mod12(16'(16'(nirb_q) * 16'd5)) : 4'd0;

  assign beat_last = (beat_q == 4'(nsym_q - 4'd1));
  assign fill      = Overlap && !skid_vld_q && !beat_last;

  // Next-state and datapath updates for the request sequencer.
  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    skip_d     = skip_q;
    pos_d      = pos_q;
    coll_d     = coll_q;
    ncs_d      = ncs_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    beat_d     = beat_q;
    sym_d      = sym_q;
    u_d        = u_q;
    k_d        = k_q;
    err_d      = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        x1_d       = 31'd1;
        x2_d       = {21'd0, nid_q};
        skip_d     = load_skip;
        u_d        = mod30(nid_q);
        k_d        = mod12(16'(m0_q) + 16'(mcs_q) + 16'(mint12));
        beat_d     = 4'd0;
        sym_d      = sym_start_q;
        skid_vld_d = 1'b0;
        state_d    = StAdvance;
      end
      StAdvance: begin
        x1_d   = x1_nxt;
        x2_d   = x2_nxt;
        skip_d = skip_q - ParStep;
        if (skip_q == ParStep) begin
          pos_d   = 3'd0;
          coll_d  = 8'd0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        x1_d   = x1_nxt;
        x2_d   = x2_nxt;
        coll_d = coll_merged;
        pos_d  = 3'(pos_q + 3'(PAR_BITS));
        if (coll_done) begin
          ncs_d   = coll_merged;
          state_d = StStream;
        end
      end
      StStream: begin
        if (fill) begin
          x1_d       = x1_nxt;
          x2_d       = x2_nxt;
          skid_d     = c_bits;
          skid_vld_d = 1'b1;
        end
        if (i_ready) begin
          if (beat_last) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 4'd1;
            sym_d  = sym_q + 4'd1;
            if (Overlap) begin
              // Bypass the skid when the byte is being gathered in this same cycle.
              ncs_d      = skid_vld_q ? skid_q : c_bits;
              skid_vld_d = 1'b0;
            end else begin
              pos_d   = 3'd0;
              coll_d  = 8'd0;
              state_d = StCollect;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and captured-config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ext_cp_q    <= 1'b0;
      interlace_q <= 1'b0;
      m0_q        <= '0;
      mcs_q       <= '0;
      sym_start_q <= '0;
      nsym_q      <= '0;
      nirb_q      <= '0;
      nslot_q     <= '0;
      nid_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      skip_q      <= '0;
      pos_q       <= '0;
      coll_q      <= '0;
      ncs_q       <= '0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      beat_q      <= '0;
      sym_q       <= '0;
      u_q         <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      skip_q     <= skip_d;
      pos_q      <= pos_d;
      coll_q     <= coll_d;
      ncs_q      <= ncs_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      beat_q     <= beat_d;
      sym_q      <= sym_d;
      u_q        <= u_d;
      k_q        <= k_d;
      err_q      <= err_d;
      if (capture) begin
        ext_cp_q    <= i_ext_cp;
        interlace_q <= i_interlace;
        m0_q        <= i_m0;
        mcs_q       <= i_mcs;
        sym_start_q <= i_sym_start;
        nsym_q      <= i_nsym;
        nirb_q      <= i_nirb;
        nslot_q     <= i_nslot;
        nid_q       <= i_nid;
      end
    end
  end

  assign o_busy    = (state_q != StIdle);
  assign o_err     = err_q;
  assign o_u       = u_q;
  assign o_valid   = (state_q == StStream);
  assign o_ncs     = ncs_q;
  assign o_alpha   = mod12(16'(k_q) + 16'(ncs_q));
  assign o_sym_idx = sym_q;
  assign o_last    = o_valid && beat_last;

endmodule

// File: tb/tb_pucch_alpha_seq_gen.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_pucch_alpha_seq_gen;

  localparam int NC   = 1600;
  localparam int MAXN = 19700;

  typedef struct {
    int ext, m0, mcs, il, nirb, nslot, nid, ls, nsym, k, u;
  } vec_t;

  typedef struct {
    logic [7:0] ncs;
    logic [3:0] alpha;
    logic [3:0] sym;
    logic       last;
    logic [4:0] u;
    int         first_cyc;
    int         hs_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ext_cp = 0, interlace = 0;
  logic [3:0] m0 = 0, mcs = 0, sym_start = 0, nsym = 0, nirb = 0;
  logic [7:0] nslot = 0;
  logic [9:0] nid = 0;
  logic       start8 = 0, start1 = 0, rdy8 = 1, rdy1 = 1, rnd_rdy = 0;

  logic       busy8, err8, v8, last8, busy1, err1, v1, last1;
  logic [4:0] u8, u1;
  logic [3:0] alpha8, sym8, alpha1, sym1;
  logic [7:0] ncs8, ncs1;

  pucch_alpha_seq_gen #(.PAR_BITS(8), .NC(NC), .N_SC(12), .NIRB_W(4)) dut8 (
    .clk(clk), .rst(rst), .i_start(start8), .i_ext_cp(ext_cp), .i_m0(m0), .i_mcs(mcs),
    .i_interlace(interlace), .i_nirb(nirb), .i_nslot(nslot), .i_nid(nid),
    .i_sym_start(sym_start), .i_nsym(nsym), .i_ready(rdy8), .o_busy(busy8), .o_err(err8),
    .o_u(u8), .o_valid(v8), .o_alpha(alpha8), .o_ncs(ncs8), .o_sym_idx(sym8), .o_last(last8)
  );

  pucch_alpha_seq_gen #(.PAR_BITS(1), .NC(NC), .N_SC(12), .NIRB_W(4)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_ext_cp(ext_cp), .i_m0(m0), .i_mcs(mcs),
    .i_interlace(interlace), .i_nirb(nirb), .i_nslot(nslot), .i_nid(nid),
    .i_sym_start(sym_start), .i_nsym(nsym), .i_ready(rdy1), .o_busy(busy1), .o_err(err1),
    .o_u(u1), .o_valid(v1), .o_alpha(alpha1), .o_ncs(ncs1), .o_sym_idx(sym1), .o_last(last1)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q8[$];
  exp_t q1[$];
  bit   x1m[MAXN];
  bit   x2m[MAXN];
  logic pv[2], pr[2];
  logic [21:0] pout[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", name, d, cyc, got, exp);
    end
  endtask

  // Bit-serial Gold reference: x1(n+31)=x1(n+3)^x1(n), x2(n+31)=x2(n+3)^x2(n+2)^x2(n+1)^x2(n).
  task automatic gold_init(input int cinit);
    for (int i = 0; i < 31; i++) begin
      x1m[i] = (i == 0);
      x2m[i] = ((cinit >> i) & 1) != 0;
    end
    for (int n = 0; n + 31 < MAXN; n++) begin
      x1m[n+31] = x1m[n+3] ^ x1m[n];
      x2m[n+31] = x2m[n+3] ^ x2m[n+2] ^ x2m[n+1] ^ x2m[n];
    end
  endtask

  function automatic logic [7:0] gold_ncs(input int s_abs);
    logic [7:0] r;
    for (int m = 0; m < 8; m++) r[m] = x1m[8*s_abs + m + NC] ^ x2m[8*s_abs + m + NC];
    return r;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q8.size() : q1.size();
  endfunction

  task automatic drive_cfg(input vec_t v);
    ext_cp    = 1'(v.ext);
    m0        = 4'(v.m0);
    mcs       = 4'(v.mcs);
    interlace = 1'(v.il);
    nirb      = 4'(v.nirb);
    nslot     = 8'(v.nslot);
    nid       = 10'(v.nid);
    sym_start = 4'(v.ls);
    nsym      = 4'(v.nsym);
  endtask

  // timed=1 also fixes the handshake cycle of every beat (ready held high).
  task automatic issue(input int d, input vec_t v, input bit timed);
    int   p, nsymb, skip, lat, gap;
    exp_t e;
    @(posedge clk); #1;
    drive_cfg(v);
    if (d == 0) start8 = 1'b1; else start1 = 1'b1;
    p     = (d == 0) ? 8 : 1;
    nsymb = v.ext ? 12 : 14;
    skip  = NC + 8 * (nsymb * v.nslot + v.ls);
    lat   = 2 + skip / p + 8 / p;
    gap   = (p == 8) ? 1 : 8 / p + 1;
    gold_init(v.nid);
    for (int b = 0; b < v.nsym; b++) begin
      e.ncs       = gold_ncs(nsymb * v.nslot + v.ls + b);
      e.alpha     = 4'((v.k + int'(e.ncs)) % 12);
      e.sym       = 4'(v.ls + b);
      e.last      = (b == v.nsym - 1);
      e.u         = 5'(v.u);
      e.first_cyc = (b == 0) ? cyc + lat : -1;
      e.hs_cyc    = timed ? cyc + lat + b * gap : -1;
      if (d == 0) q8.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_drain(input int d, input int budget);
    int n = 0;
    while (qsize(d) > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_remaining", d, 32'(qsize(d)), 0);
    if (d == 0) q8.delete(); else q1.delete();
    repeat (2) @(negedge clk);
    chk("busy_clear", d, (d == 0) ? busy8 : busy1, 0);
  endtask

  task automatic check_err(input vec_t v);
    @(posedge clk); #1;
    drive_cfg(v);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    chk("err_pulse", 0, err8, 1);
    chk("err_busy", 0, busy8, 0);
    @(negedge clk);
    chk("err_one_cycle", 0, err8, 0);
    chk("err_busy_after", 0, busy8, 0);
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [16:0] o,
                     input logic [4:0] u);
    exp_t e;
    if (rst) begin
      pv[d] = 1'b0;
      pr[d] = 1'b0;
    end else begin
      if (pv[d] && !pr[d]) begin
        chk("stall_valid", d, v, 1);
        chk("stall_hold", d, {u, o}, pout[d]);
      end
      if (v) begin
        if (qsize(d) == 0) begin
          chk("unexpected_beat", d, 1, 0);
        end else begin
          if (d == 0) e = q8[0]; else e = q1[0];
          if (!pv[d] && e.first_cyc >= 0) chk("first_latency", d, cyc, e.first_cyc);
          if (r) begin
            if (d == 0) void'(q8.pop_front()); else void'(q1.pop_front());
            chk("ncs", d, o[16:9], e.ncs);
            chk("alpha", d, o[8:5], e.alpha);
            chk("sym_idx", d, o[4:1], e.sym);
            chk("last", d, o[0], e.last);
            chk("u", d, u, e.u);
            if (e.hs_cyc >= 0) chk("beat_cycle", d, cyc, e.hs_cyc);
          end
        end
      end
      pv[d]   = v;
      pr[d]   = r;
      pout[d] = {u, o};
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, v8, rdy8, {ncs8, alpha8, sym8, last8}, u8);
    mon(1, v1, rdy1, {ncs1, alpha1, sym1, last1}, u1);
  end

  // Random back-pressure when enabled.
  always begin
    @(posedge clk); #1;
    if (rnd_rdy) begin
      rdy8 = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk_zero8(input string name);
    chk({name, "_busy"}, 0, busy8, 0);
    chk({name, "_valid"}, 0, v8, 0);
    chk({name, "_u"}, 0, u8, 0);
    chk({name, "_alpha"}, 0, alpha8, 0);
    chk({name, "_ncs"}, 0, ncs8, 0);
    chk({name, "_sym"}, 0, sym8, 0);
    chk({name, "_last"}, 0, last8, 0);
    chk({name, "_err"}, 0, err8, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vc, vd, ve, vf, vg, e1, e2, e3, e4;
    int   n;
    va = '{0, 0, 0, 0, 0, 0, 0, 0, 14, 0, 0};
    vb = '{0, 11, 11, 0, 0, 159, 1023, 10, 4, 10, 3};
    vc = '{0, 3, 0, 1, 7, 5, 100, 2, 5, 2, 10};
    vd = '{1, 5, 4, 0, 0, 39, 517, 0, 12, 9, 7};
    ve = '{0, 2, 7, 0, 0, 2, 333, 1, 13, 9, 3};
    vf = '{0, 1, 1, 0, 0, 0, 45, 0, 3, 2, 15};
    vg = '{0, 3, 0, 1, 7, 0, 0, 3, 2, 2, 0};
    e1 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    e2 = '{1, 0, 0, 0, 0, 0, 0, 10, 3, 0, 0};
    e3 = '{1, 0, 0, 0, 0, 40, 0, 0, 1, 0, 0};
    e4 = '{0, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero8("reset");
    chk("reset_busy", 1, busy1, 0);
    chk("reset_valid", 1, v1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero8("post_reset");

    // Baseline, interlace, boundary and extended-CP requests at one beat per clock.
    issue(0, va, 1'b1);
    wait_drain(0, 400);
    issue(0, vb, 1'b1);
    wait_drain(0, 2600);
    issue(0, vc, 1'b1);
    wait_drain(0, 400);

    // A start while busy is ignored and new config inputs do not disturb the request.
    issue(0, vd, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    drive_cfg(e4);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drive_cfg(e1);
    @(negedge clk);
    chk("busy_start_err", 0, err8, 0);
    chk("busy_start_busy", 0, busy8, 1);
    wait_drain(0, 800);

    // Back-pressure on both parallelism settings.
    rnd_rdy = 1'b1;
    issue(0, ve, 1'b0);
    wait_drain(0, 3000);
    issue(1, vf, 1'b0);
    wait_drain(1, 4000);
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    rdy8 = 1'b1;
    rdy1 = 1'b1;
    issue(1, vg, 1'b1);
    wait_drain(1, 2000);

    // Rejected requests.
    check_err(e1);
    check_err(e2);
    check_err(e3);
    check_err(e4);

    // Reset during ADVANCE.
    issue(0, vb, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero8("rst_advance");
    q8.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset during STREAM while stalled.
    rdy8 = 1'b0;
    issue(0, vc, 1'b0);
    n = 0;
    while (!v8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("stream_reached", 0, v8, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_zero8("rst_stream");
    q8.delete();
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rdy8 = 1'b1;
    issue(0, va, 1'b1);
    wait_drain(0, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
